// File: rtl/katadc_cal_pkg.sv
// rtl/katadc_cal_pkg.sv - shared types and widths for the KAT ADC phase calibrator
package katadc_cal_pkg;

  localparam int PHASE_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REWIND,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_PS_REQ,
    ST_PS_WAIT,
    ST_RETURN,
    ST_DONE,
    ST_FAIL
  } cal_state_e;

  // Where a completed phase move hands control back to.
  typedef enum logic [1:0] {
    MV_SWEEP,
    MV_REWIND,
    MV_RETURN
  } move_kind_e;

endpackage

// File: rtl/katadc_pattern_check.sv
// rtl/katadc_pattern_check.sv - one DWELL-cycle test-pattern check window per start pulse
module katadc_pattern_check
  import katadc_cal_pkg::*;
#(
  parameter int          DWELL   = 256,
  parameter logic [7:0]  PATTERN = 8'h5A,
  parameter int          CW      = $clog2(DWELL + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_valid,
  input  logic [31:0]   i_datai,
  input  logic [31:0]   i_dataq,
  output logic [CW-1:0] o_valid_cnt,
  output logic          o_err,
  output logic          o_done
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic          r_active;
  logic [CW-1:0] r_cycle;
  logic [CW-1:0] r_valid_cnt;
  logic          r_err;
  logic          r_done;
  logic          w_mismatch;

  always_comb begin
    w_mismatch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((i_datai[8*k +: 8] != PATTERN) || (i_dataq[8*k +: 8] != PATTERN)) begin
        w_mismatch = 1'b1;
      end
    end
  end

  // Results hold after the window closes until the next start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active    <= 1'b0;
      r_cycle     <= '0;
      r_valid_cnt <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active    <= 1'b1;
        r_cycle     <= '0;
        r_valid_cnt <= '0;
        r_err       <= 1'b0;
      end else if (r_active) begin
        if (i_valid) begin
          r_valid_cnt <= r_valid_cnt + CW'(1);
          if (w_mismatch) r_err <= 1'b1;
        end
        if (r_cycle == LAST) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
        r_cycle <= r_cycle + CW'(1);
      end
    end
  end

  assign o_valid_cnt = r_valid_cnt;
  assign o_err       = r_err;
  assign o_done      = r_done;

endmodule

// File: rtl/katadc_phase_cal.sv
// rtl/katadc_phase_cal.sv - sweeps DCM fine phase, finds the widest clean eye, parks at its centre
module katadc_phase_cal
  import katadc_cal_pkg::*;
#(
  parameter int         NUM_STEPS  = 64,
  parameter int         DWELL      = 256,
  parameter int         SETTLE     = 16,
  parameter int         PS_TIMEOUT = 1024,
  parameter logic [7:0] PATTERN    = 8'h5A
) (
  input  logic               ctrl_clk_in,
  input  logic               ctrl_reset,
  input  logic               cal_start,
  input  logic               ctrl_dcm_locked,
  input  logic               user_data_valid,
  input  logic [31:0]        user_datai,
  input  logic [31:0]        user_dataq,
  output logic               dcm_psen,
  output logic               dcm_psincdec,
  input  logic               dcm_psdone,
  output logic               cal_busy,
  output logic               cal_done,
  output logic               cal_fail,
  output logic [PHASE_W-1:0] cal_phase,
  output logic [PHASE_W-1:0] cal_eye_width
);

  localparam int                 CW          = $clog2(DWELL + 1);
  localparam logic [PHASE_W-1:0] ONE         = {{(PHASE_W-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0] LAST_POS    = PHASE_W'(NUM_STEPS - 1);
  localparam logic [15:0]        SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0]        PS_LAST     = 16'(PS_TIMEOUT - 1);

  cal_state_e                r_state, w_next;
  move_kind_e                r_kind;
  logic                      r_incdec;
  logic                      r_fail_after;
  logic signed [PHASE_W-1:0] r_phase;
  logic signed [PHASE_W-1:0] r_centre;
  logic [PHASE_W-1:0]        r_run_len, r_run_start, r_best_len, r_best_start, r_eye_width;
  logic [15:0]               r_cnt;

  logic                      w_idle_like, w_busy, w_accept;
  logic                      w_win_start, w_win_done, w_win_err;
  logic [CW-1:0]             w_valid_cnt;
  logic                      w_good, w_last, w_take;
  logic [PHASE_W-1:0]        w_pos, w_run_start_nx, w_close_len, w_best_len_nx, w_best_start_nx;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign w_busy      = !w_idle_like;
  assign w_accept    = w_idle_like && cal_start;
  assign w_win_start = (r_state == ST_SETTLE) && (r_cnt == SETTLE_LAST);

  katadc_pattern_check #(
    .DWELL   (DWELL),
    .PATTERN (PATTERN),
    .CW      (CW)
  ) u_check (
    .i_clk       (ctrl_clk_in),
    .i_reset     (ctrl_reset),
    .i_start     (w_win_start),
    .i_valid     (user_data_valid),
    .i_datai     (user_datai),
    .i_dataq     (user_dataq),
    .o_valid_cnt (w_valid_cnt),
    .o_err       (w_win_err),
    .o_done      (w_win_done)
  );

  // Run bookkeeping for the position being evaluated; a run also closes at the last position.
  assign w_pos           = r_phase;
  assign w_good          = (w_valid_cnt != '0) && !w_win_err;
  assign w_last          = (w_pos == LAST_POS);
  assign w_run_start_nx  = (w_good && (r_run_len == '0)) ? w_pos : r_run_start;
  assign w_close_len     = w_good ? (r_run_len + ONE) : r_run_len;
  assign w_take          = (!w_good || w_last) && (w_close_len > r_best_len);
  assign w_best_len_nx   = w_take ? w_close_len : r_best_len;
  assign w_best_start_nx = w_take ? w_run_start_nx : r_best_start;

  always_ff @(posedge ctrl_clk_in) begin
    if (ctrl_reset) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: if (cal_start) w_next = ST_REWIND;
      ST_REWIND: begin
        if (r_phase != '0)     w_next = ST_PS_REQ;
        else if (r_fail_after) w_next = ST_FAIL;
        else                   w_next = ST_SETTLE;
      end
      ST_SETTLE:  if (r_cnt == SETTLE_LAST) w_next = ST_MEASURE;
      ST_MEASURE: if (w_win_done) w_next = ST_EVAL;
      ST_EVAL: begin
        if (!w_last)                   w_next = ST_PS_REQ;
        else if (w_best_len_nx == '0)  w_next = ST_REWIND;
        else                           w_next = ST_RETURN;
      end
      ST_PS_REQ: w_next = ST_PS_WAIT;
      ST_PS_WAIT: begin
        if (dcm_psdone) begin
          case (r_kind)
            MV_SWEEP:  w_next = ST_SETTLE;
            MV_REWIND: w_next = ST_REWIND;
            default:   w_next = ST_RETURN;
          endcase
        end else if (r_cnt >= PS_LAST) begin
          w_next = ST_FAIL;
        end
      end
      ST_RETURN: w_next = (r_phase == r_centre) ? ST_DONE : ST_PS_REQ;
      default:   w_next = ST_IDLE;
    endcase
    // A DCM that loses lock has also lost its phase, so nothing measured so far is usable.
    if (w_busy && !ctrl_dcm_locked) w_next = ST_FAIL;
  end

  always_ff @(posedge ctrl_clk_in) begin
    if (ctrl_reset) begin
      r_kind       <= MV_SWEEP;
      r_incdec     <= 1'b0;
      r_fail_after <= 1'b0;
      r_phase      <= '0;
      r_centre     <= '0;
      r_run_len    <= '0;
      r_run_start  <= '0;
      r_best_len   <= '0;
      r_best_start <= '0;
      r_eye_width  <= '0;
      r_cnt        <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;

      if (w_accept) begin
        r_fail_after <= 1'b0;
        r_run_len    <= '0;
        r_run_start  <= '0;
        r_best_len   <= '0;
        r_best_start <= '0;
        r_eye_width  <= '0;
      end

      if (w_next == ST_PS_REQ) begin
        case (r_state)
          ST_EVAL: begin
            r_kind   <= MV_SWEEP;
            r_incdec <= 1'b1;
          end
          ST_REWIND: begin
            r_kind   <= MV_REWIND;
            r_incdec <= 1'b0;
          end
          default: begin
            r_kind   <= MV_RETURN;
            r_incdec <= 1'b0;
          end
        endcase
      end

      if (r_state == ST_EVAL) begin
        r_run_len    <= w_good ? w_close_len : '0;
        r_run_start  <= w_run_start_nx;
        r_best_len   <= w_best_len_nx;
        r_best_start <= w_best_start_nx;
        r_centre     <= $signed(w_best_start_nx + (w_best_len_nx >> 1));
        if (w_last && (w_best_len_nx == '0)) r_fail_after <= 1'b1;
      end

      if ((r_state == ST_RETURN) && (w_next == ST_DONE)) r_eye_width <= r_best_len;

      if (w_busy && !ctrl_dcm_locked) begin
        r_phase <= '0;
      end else if ((r_state == ST_PS_WAIT) && dcm_psdone) begin
        r_phase <= r_incdec ? (r_phase + $signed(ONE)) : (r_phase - $signed(ONE));
      end
    end
  end

  assign dcm_psen      = (r_state == ST_PS_REQ) && ctrl_dcm_locked && !ctrl_reset;
  assign dcm_psincdec  = dcm_psen && r_incdec;
  assign cal_busy      = w_busy;
  assign cal_done      = (r_state == ST_DONE);
  assign cal_fail      = (r_state == ST_FAIL);
  assign cal_phase     = r_phase;
  assign cal_eye_width = r_eye_width;

endmodule

// File: tb/tb_katadc_phase_cal.sv
// tb/tb_katadc_phase_cal.sv - directed bench for katadc_phase_cal with a DCM/ADC pattern model
module tb_katadc_phase_cal;

  localparam logic [31:0] PAT32 = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cal_start = 1'b0;
  logic        locked = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] datai = '0;
  logic [31:0] dataq = '0;
  logic        m_psdone = 1'b0;
  logic        man_psdone = 1'b0;
  logic        psdone;
  logic        psen, psincdec, busy, done, fail;
  logic [15:0] phase, eye;

  assign psdone = m_psdone | man_psdone;

  katadc_phase_cal #(
    .NUM_STEPS  (16),
    .DWELL      (8),
    .SETTLE     (4),
    .PS_TIMEOUT (20),
    .PATTERN    (8'h5A)
  ) dut (
    .ctrl_clk_in     (clk),
    .ctrl_reset      (rst),
    .cal_start       (cal_start),
    .ctrl_dcm_locked (locked),
    .user_data_valid (valid),
    .user_datai      (datai),
    .user_dataq      (dataq),
    .dcm_psen        (psen),
    .dcm_psincdec    (psincdec),
    .dcm_psdone      (psdone),
    .cal_busy        (busy),
    .cal_done        (done),
    .cal_fail        (fail),
    .cal_phase       (phase),
    .cal_eye_width   (eye)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  int          cyc = 0;
  int          m_phase = 0;
  int          m_delay = 0;
  int          m_dir = 0;
  bit          m_pend = 1'b0;
  int          hold_at = -1;
  int          n_inc = 0, n_dec = 0, n_dec_first = 0, n_overlap = 0;
  int          psen_cyc = 0;
  logic [15:0] good_mask = '0;
  logic [15:0] novalid_mask = '0;
  logic [31:0] bad;

  always @(posedge clk) cyc <= cyc + 1;

  // DCM phase-shift port plus an ADC emitting the test pattern only at "good" phases.
  always @(negedge clk) begin
    m_psdone = 1'b0;
    if (rst || !locked) begin
      m_phase = 0;
      m_pend  = 1'b0;
    end else if (m_pend) begin
      if (m_delay == 0) begin
        m_psdone = 1'b1;
        m_phase  = m_phase + m_dir;
        m_pend   = 1'b0;
      end else begin
        m_delay = m_delay - 1;
      end
    end
    if (psen) begin
      if (m_pend) n_overlap++;
      if (psincdec) n_inc++;
      else begin
        n_dec++;
        if (n_inc == 0) n_dec_first++;
      end
      psen_cyc = cyc;
      if (!(psincdec && (m_phase == hold_at))) begin
        m_pend  = 1'b1;
        m_delay = 2;
        m_dir   = psincdec ? 1 : -1;
      end
    end
    if (novalid_mask[m_phase[3:0]]) begin
      valid = 1'b0;
      datai = 32'hFFFF_FFFF;
      dataq = 32'hFFFF_FFFF;
    end else if (good_mask[m_phase[3:0]]) begin
      valid = cyc[0];
      datai = cyc[0] ? PAT32 : 32'h00FF_1234;
      dataq = cyc[0] ? PAT32 : 32'hA5A5_0000;
    end else begin
      valid = 1'b1;
      bad   = PAT32 ^ (32'h1 << (8 * (m_phase % 4)));
      datai = m_phase[2] ? bad : PAT32;
      dataq = m_phase[2] ? PAT32 : bad;
    end
  end

  task automatic start_cal(input string tag);
    @(negedge clk);
    n_inc = 0; n_dec = 0; n_dec_first = 0; n_overlap = 0;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    check_val({tag, ".busy_up"}, int'(busy), 1);
    check_val({tag, ".eye_clr"}, int'(eye), 0);
    check_val({tag, ".flags_clr"}, int'({done, fail}), 0);
  endtask

  task automatic wait_idle(input string tag, input int poke);
    int k = 0;
    while (busy && (k < 4000)) begin
      cal_start = (k == poke);
      @(negedge clk);
      k++;
    end
    cal_start = 1'b0;
    check_val({tag, ".finish"}, int'(k < 4000), 1);
  endtask

  task automatic check_end(input string tag, input int ph, input int ew, input int dn, input int fl);
    check_val({tag, ".phase"}, int'(phase), ph);
    check_val({tag, ".eye"}, int'(eye), ew);
    check_val({tag, ".done"}, int'(done), dn);
    check_val({tag, ".fail"}, int'(fail), fl);
  endtask

  int k, base;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst.busy", int'(busy), 0);
    check_val("rst.psen", int'(psen), 0);
    check_val("rst.psincdec", int'(psincdec), 0);
    check_end("rst", 0, 0, 0, 0);

    good_mask = 16'h07E0;
    start_cal("r1");
    wait_idle("r1", 100);
    check_end("r1", 8, 6, 1, 0);
    check_val("r1.inc", n_inc, 15);
    check_val("r1.dec", n_dec, 7);
    check_val("r1.overlap", n_overlap, 0);

    good_mask = 16'h0E1C;
    start_cal("r2");
    wait_idle("r2", -1);
    check_end("r2", 3, 3, 1, 0);
    check_val("r2.rewind", n_dec_first, 8);
    check_val("r2.dec", n_dec, 20);

    good_mask = 16'h8000;
    start_cal("r3");
    wait_idle("r3", -1);
    check_end("r3", 15, 1, 1, 0);
    check_val("r3.dec", n_dec, 3);

    good_mask = 16'h07E0;
    novalid_mask = 16'h0080;
    start_cal("r4");
    wait_idle("r4", -1);
    check_end("r4", 9, 3, 1, 0);
    check_val("r4.dec", n_dec, 21);
    novalid_mask = '0;

    good_mask = 16'h0000;
    start_cal("r5");
    wait_idle("r5", -1);
    check_end("r5", 0, 0, 0, 1);
    check_val("r5.inc", n_inc, 15);
    check_val("r5.dec", n_dec, 24);

    good_mask = 16'h07E0;
    hold_at = 6;
    start_cal("r6");
    wait_idle("r6", -1);
    check_val("r6.timeout_cycles", cyc - psen_cyc, 21);
    check_end("r6", 6, 0, 0, 1);
    check_val("r6.inc", n_inc, 7);
    hold_at = -1;
    repeat (20) @(negedge clk);
    check_val("r6.quiet", n_inc + n_dec, 7);

    start_cal("r7");
    wait_idle("r7", -1);
    check_val("r7.rewind", n_dec_first, 6);
    check_val("r7.inc", n_inc, 15);
    check_end("r7", 8, 6, 1, 0);

    start_cal("r8");
    k = 0;
    while (!((n_inc == 3) && (m_phase == 3)) && (k < 2000)) begin
      @(negedge clk);
      k++;
    end
    check_val("r8.reach", int'(k < 2000), 1);
    repeat (6) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    check_val("r8.fail", int'(fail), 1);
    check_val("r8.phase", int'(phase), 0);
    check_val("r8.busy", int'(busy), 0);
    base = n_inc + n_dec;
    repeat (20) @(negedge clk);
    check_val("r8.quiet", n_inc + n_dec, base);
    locked = 1'b1;

    hold_at = 2;
    start_cal("r9");
    k = 0;
    while ((n_inc < 3) && (k < 2000)) begin
      @(negedge clk);
      k++;
    end
    check_val("r9.reach", int'(k < 2000), 1);
    repeat (2) @(negedge clk);
    check_val("r9.pre_phase", int'(phase), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("r9.busy", int'(busy), 0);
    check_val("r9.psen", int'(psen), 0);
    check_end("r9", 0, 0, 0, 0);
    hold_at = -1;
    man_psdone = 1'b1;
    @(negedge clk);
    man_psdone = 1'b0;
    base = n_inc + n_dec;
    repeat (20) @(negedge clk);
    check_val("r9.late_phase", int'(phase), 0);
    check_val("r9.late_busy", int'(busy), 0);
    check_val("r9.quiet", n_inc + n_dec, base);

    start_cal("r10");
    wait_idle("r10", -1);
    check_val("r10.rewind", n_dec_first, 0);
    check_val("r10.inc", n_inc, 15);
    check_end("r10", 8, 6, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/katadc_phase_cal.md
Name: katadc_phase_cal

Overview:
- Calibrates the capture-clock phase of the KAT ADC interface while the ADC outputs a static test pattern.
- Steps the interface DCM fine phase shift across a window and checks captured I/Q words at each step.
- Finds the longest contiguous run of error-free steps, then parks the DCM at the centre of that run.
- Drives the interface's dcm_psen/dcm_psincdec/dcm_psdone handshake. dcm_psclk is tied to ctrl_clk_in at system level.

Parameters:
NUM_STEPS, 64, number of phase positions swept (positions 0..NUM_STEPS-1)
DWELL, 256, clock cycles of error checking per position
SETTLE, 16, cycles waited after dcm_psdone before checking starts
PS_TIMEOUT, 1024, max cycles from dcm_psen pulse to dcm_psdone
PATTERN, 8'h5A, expected value on every I and Q lane in test mode

Ports:
ctrl_clk_in  in  1  block clock (ADC-derived control clock)
ctrl_reset  in  1  synchronous active-high reset
cal_start  in  1  one-cycle start request
ctrl_dcm_locked  in  1  DCM lock from ADC interface
user_data_valid  in  1  captured data valid
user_datai  in  32  {datai3,datai2,datai1,datai0}
user_dataq  in  32  {dataq3,dataq2,dataq1,dataq0}
dcm_psen  out  1  phase-shift enable pulse
dcm_psincdec  out  1  1=increment, 0=decrement; valid with dcm_psen
dcm_psdone  in  1  phase-shift complete
cal_busy  out  1  calibration in progress
cal_done  out  1  sticky: last calibration succeeded
cal_fail  out  1  sticky: last calibration failed
cal_phase  out  16  signed current DCM phase offset in steps
cal_eye_width  out  16  length of best good run

Behaviour:
- Clocking and reset: one clock, ctrl_clk_in; reset is synchronous and active-high (ctrl_reset).
- Reset values: all outputs 0; state IDLE; phase counter 0.
- cal_start is accepted only in IDLE, DONE or FAIL; it is ignored while busy.
- Accepting cal_start clears cal_done/cal_fail and cal_eye_width, and sets cal_busy the next cycle.
- States:
  - IDLE.
  - REWIND: decrement until phase = 0. Skipped if phase is already 0.
  - SETTLE.
  - MEASURE.
  - EVAL.
  - PS_REQ / PS_WAIT: shared by sweep, rewind and return moves.
  - RETURN: decrement to centre.
  - DONE.
  - FAIL.
- Phase move handshake:
  - PS_REQ drives dcm_psen high for exactly one cycle, with dcm_psincdec set.
  - PS_WAIT waits for dcm_psdone. Phase counter updates ±1 on the dcm_psdone cycle.
  - No second psen is issued before psdone.
- Sweep order: SETTLE → MEASURE at position 0, then EVAL. If position < NUM_STEPS-1, increment and repeat.
- MEASURE:
  - Lasts exactly DWELL cycles.
  - An error is counted when user_data_valid=1 and any of the 8 lane bytes ≠ PATTERN.
  - A position is good iff valid samples ≥ 1 and errors = 0.
- EVAL run tracking:
  - Good position: extend the current run (run_start is latched on the first good position).
  - Bad position, or final position: close the run.
  - A closed run replaces the best only if strictly longer, so the earliest run wins ties.
- After the last position:
  - best_len = 0: rewind to 0, then go to FAIL.
  - Otherwise centre = best_start + floor(best_len/2). Decrement from NUM_STEPS-1 to centre, then go to DONE with cal_eye_width = best_len.
- psdone timeout: counter exceeds PS_TIMEOUT in PS_WAIT → FAIL immediately. Phase is unchanged for that move; psen stays low.
- ctrl_dcm_locked low while busy → FAIL next cycle, phase counter forced to 0 (DCM re-lock resets its phase).
- cal_busy is low in IDLE/DONE/FAIL. cal_done and cal_fail are never both 1.
- Reset mid-operation: abort the same cycle with no further psen. The phase counter resets to 0; system reset also resets the DCM.

Decomposition:
- Package katadc_cal_pkg: state enum, and a PHASE_W = 16 constant.
- Sub-module katadc_pattern_check: one DWELL window per start pulse. Outputs are the valid-sample count, the error flag and a window-done pulse.
- Phase/run tracking and the FSM live in the top.

Test Plan:
- NUM_STEPS=16, DWELL=8, SETTLE=4; model data good only at positions 5..10:
  - 15 increment pulses, then 7 decrement pulses.
  - cal_phase=8, cal_eye_width=6, cal_done=1.
- Good at 2..4 and 9..11 (tie) → centre 3, eye width 3. Good only at 15 (run at end) → centre 15, 0 decrements.
- All positions bad → 15 increments then 15 decrements; cal_phase=0, cal_fail=1, cal_eye_width=0.
- Model withholds psdone at position 6 with PS_TIMEOUT=20:
  - FAIL 21 cycles after psen; cal_phase=6.
  - Next cal_start rewinds with 6 decrements before sweeping.
- Drop ctrl_dcm_locked during MEASURE → next cycle cal_fail=1, cal_phase=0, cal_busy=0, no further psen.
- Assert ctrl_reset during PS_WAIT, then issue a late psdone → all outputs 0, state IDLE, phase stays 0.
- Pulse cal_start while busy → ignored, sequence unchanged.
